// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state codes and JEDEC helpers for the SPI flash responder.
package spi_flash_pkg;
    localparam logic [7:0]  OP_READ = 8'h03;
    localparam logic [7:0]  OP_RDID = 8'h9F;
    localparam logic [7:0]  OP_RDSR = 8'h05;
    localparam logic [23:0] JEDEC_ID_DEFAULT = 24'hEF4018;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_ID     = 3'd4;
    localparam state_t ST_STAT   = 3'd5;
    localparam state_t ST_IGNORE = 3'd6;

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            default: id_byte = id[7:0];
        endcase
    endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus SCK edge detection.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic ck,
    input  logic cs_n,
    input  logic di,
    output logic ck_rise,
    output logic ck_fall,
    output logic cs_active,
    output logic di_s
);
    logic [1:0] ck_ff, cs_ff, di_ff;
    logic       ck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_ff <= 2'b00;
            cs_ff <= 2'b11;
            di_ff <= 2'b00;
            ck_d  <= 1'b0;
        end else begin
            ck_ff <= {ck_ff[0], ck};
            cs_ff <= {cs_ff[0], cs_n};
            di_ff <= {di_ff[0], di};
            ck_d  <= ck_ff[1];
        end
    end

    assign ck_rise   = ck_ff[1] & ~ck_d;
    assign ck_fall   = ~ck_ff[1] & ck_d;
    assign cs_active = ~cs_ff[1];
    assign di_s      = di_ff[1];
endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash slave serving READ / RDID / RDSR from a byte-wide memory port,
// with all SPI pins oversampled in the system clock domain.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = JEDEC_ID_DEFAULT
) (
    input  logic              io_axiClk,
    input  logic              io_axiReset,
    input  logic              flash_ck,
    input  logic              flash_cs_n,
    input  logic              flash_di,
    output logic              flash_do,
    output logic              flash_do_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    logic        ck_rise, ck_fall, cs_active, di_s;
    state_t      state;
    logic [4:0]  bit_cnt;
    logic [22:0] in_sr;
    logic [23:0] in_next;
    logic [7:0]  shreg, pf, cur;
    logic [1:0]  id_idx;
    logic        rd_pend;
    logic        armed;
    logic [1:0]  rst_sh;

    spi_pin_sync u_sync (
        .clk       (io_axiClk),
        .rst       (io_axiReset),
        .ck        (flash_ck),
        .cs_n      (flash_cs_n),
        .di        (flash_di),
        .ck_rise   (ck_rise),
        .ck_fall   (ck_fall),
        .cs_active (cs_active),
        .di_s      (di_s)
    );

    assign busy    = cs_active;
    assign in_next = {in_sr, di_s};
    // Byte boundaries after the first driven bit take the prefetched byte.
    assign cur     = (bit_cnt[2:0] == 3'd0 && flash_do_oe) ? pf : shreg;

    always_ff @(posedge io_axiClk) begin
        if (io_axiReset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            in_sr       <= '0;
            shreg       <= '0;
            pf          <= '0;
            id_idx      <= '0;
            rd_pend     <= 1'b0;
            armed       <= 1'b0;
            rst_sh      <= '0;
            flash_do    <= 1'b0;
            flash_do_oe <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            rd_pend   <= mem_rd_en;
            rst_sh    <= {rst_sh[0], 1'b1};
            // Only re-arm once CS has truly been seen high after the synchronizers refill,
            // so a reset inside a transaction never resumes it.
            if (!cs_active && rst_sh[1])
                armed <= 1'b1;

            if (!cs_active) begin
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                flash_do    <= 1'b0;
                flash_do_oe <= 1'b0;
                rd_pend     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (ck_rise) begin
                            in_sr   <= in_next[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (in_next[7:0])
                                    OP_READ: state <= ST_ADDR;
                                    OP_RDID: begin
                                        state  <= ST_ID;
                                        shreg  <= JEDEC_ID[23:16];
                                        id_idx <= 2'd1;
                                    end
                                    OP_RDSR: begin
                                        state <= ST_STAT;
                                        shreg <= 8'h00;
                                    end
                                    default: state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (ck_rise) begin
                            in_sr   <= in_next[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                mem_addr  <= in_next[ADDR_W-1:0];
                                mem_rd_en <= 1'b1;
                            end
                        end
                        if (rd_pend) begin
                            shreg   <= mem_rdata;
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA, ST_ID, ST_STAT: begin
                        if (ck_fall) begin
                            flash_do    <= cur[7];
                            shreg       <= {cur[6:0], 1'b0};
                            flash_do_oe <= 1'b1;
                            bit_cnt     <= {2'b00, bit_cnt[2:0] + 3'd1};
                            if (bit_cnt[2:0] == 3'd7) begin
                                if (state == ST_DATA) begin
                                    mem_addr  <= mem_addr + 1'b1;
                                    mem_rd_en <= 1'b1;
                                end else if (state == ST_ID) begin
                                    pf     <= id_byte(JEDEC_ID, id_idx);
                                    id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                                end else begin
                                    pf <= 8'h00;
                                end
                            end
                        end
                        if (state == ST_DATA && rd_pend)
                            pf <= mem_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench: an SPI master model drives the responder and compares the
// returned stream and memory fetches against a byte-level reference model.
module tb_spi_flash_responder;
    localparam int HALF = 6;
    localparam int unsigned AMASK = 32'h00FF_FFFF;

    logic        io_axiClk = 1'b0;
    logic        io_axiReset;
    logic        flash_ck, flash_cs_n, flash_di;
    logic        flash_do, flash_do_oe;
    logic [23:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [int unsigned];
    int unsigned fetch_q[$];

    spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4018)) dut (
        .io_axiClk   (io_axiClk),
        .io_axiReset (io_axiReset),
        .flash_ck    (flash_ck),
        .flash_cs_n  (flash_cs_n),
        .flash_di    (flash_di),
        .flash_do    (flash_do),
        .flash_do_oe (flash_do_oe),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    always #5 io_axiClk = ~io_axiClk;

    // Synchronous memory: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge io_axiClk) begin
        int unsigned a;
        a = mem_addr;
        if (mem_rd_en) begin
            fetch_q.push_back(a);
            mem_rdata <= mem.exists(a) ? mem[a] : 8'h00;
        end else begin
            mem_rdata <= 8'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge io_axiClk);
    endtask

    task automatic spi_bit(input logic b, output logic d, output logic o);
        flash_di = b;
        wait_clk(HALF);
        d = flash_do;
        o = flash_do_oe;
        flash_ck = 1'b1;
        wait_clk(HALF);
        flash_ck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                        output logic oe_all, output logic oe_any, output logic do_any);
        logic d, o;
        rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0; do_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], d, o);
            rx[i]  = d;
            oe_all = oe_all & o;
            oe_any = oe_any | o;
            do_any = do_any | d;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        logic a, b, c;
        xfer(tx, rx, a, b, c);
    endtask

    task automatic cs_begin();
        flash_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        flash_cs_n = 1'b1;
        wait_clk(2 * HALF);
        chk("idle_oe", flash_do_oe, 1'b0);
        chk("idle_do", flash_do, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    // READ model: byte i comes from (a+i) mod 2^24; fetches are a..a+n (one prefetch ahead).
    task automatic run_read(input int unsigned a, input int n);
        logic [7:0] rx;
        logic oa, oo, dz;
        for (int i = 0; i <= n; i++)
            if (!mem.exists((a + i) & AMASK)) mem[(a + i) & AMASK] = 8'($urandom);
        fetch_q.delete();
        cs_begin();
        send(8'h03);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), rx, oa, oo, dz);
            chk("read_data", rx, mem[(a + i) & AMASK]);
            chk("read_oe", oa, 1'b1);
        end
        cs_end();
        chk("read_nfetch", fetch_q.size(), n + 1);
        for (int i = 0; i <= n && i < fetch_q.size(); i++)
            chk("read_faddr", fetch_q[i], (a + i) & AMASK);
    endtask

    task automatic run_id(input int n);
        logic [23:0] id = 24'hEF4018;
        logic [7:0] rx, e;
        logic oa, oo, dz;
        cs_begin();
        send(8'h9F);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), rx, oa, oo, dz);
            e = (i % 3 == 0) ? id[23:16] : (i % 3 == 1) ? id[15:8] : id[7:0];
            chk("id_data", rx, e);
            chk("id_oe", oa, 1'b1);
        end
        cs_end();
    endtask

    task automatic run_stat(input int n);
        logic [7:0] rx;
        logic oa, oo, dz;
        cs_begin();
        send(8'h05);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), rx, oa, oo, dz);
            chk("stat_data", rx, 8'h00);
            chk("stat_oe", oa, 1'b1);
        end
        cs_end();
    endtask

    task automatic run_ignore(input logic [7:0] op, input int n);
        logic [7:0] rx;
        logic oa, oo, dz;
        fetch_q.delete();
        cs_begin();
        send(op);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), rx, oa, oo, dz);
            chk("ign_oe", oo, 1'b0);
            chk("ign_do", dz, 1'b0);
        end
        cs_end();
        chk("ign_nfetch", fetch_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d, o, oe_any, do_any;
        logic [7:0] op;
        io_axiReset = 1'b1;
        flash_ck = 1'b0; flash_cs_n = 1'b1; flash_di = 1'b0;
        wait_clk(3);
        chk("rst_do", flash_do, 1'b0);
        chk("rst_oe", flash_do_oe, 1'b0);
        chk("rst_rd", mem_rd_en, 1'b0);
        chk("rst_addr", mem_addr, 24'h0);
        chk("rst_busy", busy, 1'b0);
        io_axiReset = 1'b0;
        wait_clk(5);

        mem[32'h10] = 8'hA5;
        mem[32'h11] = 8'h3C;
        mem[32'hFFFFFF] = 8'h11;
        mem[32'h0] = 8'h22;

        run_id(4);
        run_read(32'h10, 2);
        run_read(32'hFFFFFF, 2);
        run_ignore(8'hAB, 2);
        run_id(3);
        run_stat(2);

        // Abort mid-address, then a clean READ must use only the new address.
        fetch_q.delete();
        cs_begin();
        send(8'h03);
        for (int i = 0; i < 12; i++) spi_bit(1'($urandom), d, o);
        cs_end();
        chk("abort_nfetch", fetch_q.size(), 0);
        run_read(32'h10, 1);

        // Reset in the middle of DATA; CS stays low and SCK keeps running.
        cs_begin();
        send(8'h03); send(8'h00); send(8'h00); send(8'h10);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, d, o);
        io_axiReset = 1'b1;
        wait_clk(1);
        chk("mrst_do", flash_do, 1'b0);
        chk("mrst_oe", flash_do_oe, 1'b0);
        chk("mrst_rd", mem_rd_en, 1'b0);
        chk("mrst_addr", mem_addr, 24'h0);
        chk("mrst_busy", busy, 1'b0);
        io_axiReset = 1'b0;
        fetch_q.delete();
        oe_any = 1'b0; do_any = 1'b0;
        for (int i = 0; i < 24; i++) begin
            spi_bit(1'($urandom), d, o);
            oe_any |= o;
            do_any |= d;
        end
        chk("post_rst_oe", oe_any, 1'b0);
        chk("post_rst_do", do_any, 1'b0);
        chk("post_rst_nfetch", fetch_q.size(), 0);
        cs_end();
        run_id(3);

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: run_read($urandom & AMASK, int'($urandom_range(1, 4)));
                1: run_id(int'($urandom_range(1, 5)));
                2: run_stat(int'($urandom_range(1, 3)));
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h9F || op == 8'h05) op = 8'($urandom);
                    run_ignore(op, int'($urandom_range(1, 2)));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
